// File: rtl/add_accum_seq_if.sv
// add_accum_seq_if: burst input, adder link and result handshake bundle for add_accum_seq
interface add_accum_seq_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_ovf;
  logic [LEN_W-1:0] res_ovf_cnt;
  modport slave (
    input  start, len, in_data, in_valid, add_sum, add_ovf, res_ready,
    output in_ready, add_a, add_b, busy, res_valid, res_sum, res_ovf, res_ovf_cnt
  );
  modport master (
    output start, len, in_data, in_valid, add_sum, add_ovf, res_ready,
    input  in_ready, add_a, add_b, busy, res_valid, res_sum, res_ovf, res_ovf_cnt
  );
endinterface

// File: rtl/add_accum_seq.sv
// add_accum_seq: accumulates a burst of words through an external adder and reports sum, sticky carry and carry count
module add_accum_seq #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  add_accum_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, res_sum;
  logic [LEN_W-1:0] remaining, ovf_cnt, cnt_nx, res_ovf_cnt;
  logic             sticky, res_ovf, xfer, last;
  assign xfer   = state == ACCUM && bus.in_valid;
  assign last   = xfer && remaining == LEN_W'(1);
  assign cnt_nx = &ovf_cnt ? ovf_cnt : ovf_cnt + LEN_W'(bus.add_ovf);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state decode; start only counts in IDLE, result leaves DONE on handshake
  always_comb begin
    state_nx = state == IDLE  ? (bus.start ? (bus.len == '0 ? DONE : ACCUM) : IDLE) :
               state == ACCUM ? (last ? DONE : ACCUM) :
               (bus.res_ready ? IDLE : DONE);
  end
  // running total and carry bookkeeping; result registers persist through IDLE until the next burst ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      sticky      <= 1'b0;
      ovf_cnt     <= '0;
      remaining   <= '0;
      res_sum     <= '0;
      res_ovf     <= 1'b0;
      res_ovf_cnt <= '0;
    end else if (state == IDLE && bus.start) begin
      acc       <= '0;
      sticky    <= 1'b0;
      ovf_cnt   <= '0;
      remaining <= bus.len;
      if (bus.len == '0) begin
        res_sum     <= '0;
        res_ovf     <= 1'b0;
        res_ovf_cnt <= '0;
      end
    end else if (xfer) begin
      acc       <= bus.add_sum;
      sticky    <= sticky | bus.add_ovf;
      ovf_cnt   <= cnt_nx;
      remaining <= remaining - LEN_W'(1);
      if (last) begin
        res_sum     <= bus.add_sum;
        res_ovf     <= sticky | bus.add_ovf;
        res_ovf_cnt <= cnt_nx;
      end
    end
  end
  // outputs decoded from state; adder in2 is fed only while accumulating
  always_comb begin
    bus.in_ready    = state == ACCUM;
    bus.busy        = state != IDLE;
    bus.res_valid   = state == DONE;
    bus.add_a       = acc;
    bus.add_b       = state == ACCUM ? bus.in_data : '0;
    bus.res_sum     = res_sum;
    bus.res_ovf     = res_ovf;
    bus.res_ovf_cnt = res_ovf_cnt;
  end
endmodule

// File: tb/tb_add_accum_seq.sv
// tb_add_accum_seq: directed table, corner sequences and random bursts against an arithmetic reference
module tb_add_accum_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int xfers = 0;
  int ready_seen = 0;
  logic [15:0] words_q[$];
  logic [16:0] full;
  add_accum_seq_if #(.WIDTH(16), .LEN_W(8)) bus ();
  add_accum_seq #(.WIDTH(16), .LEN_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign full = {1'b0, bus.add_a} + {1'b0, bus.add_b};
  assign bus.add_sum = full[15:0];
  assign bus.add_ovf = full[16];
  always @(posedge clk) if (bus.in_valid && bus.in_ready) xfers++;
  always @(negedge clk) if (bus.in_ready) ready_seen++;

  typedef struct {
    int          n;
    logic [15:0] w[3];
    int          hold;
    logic [15:0] es;
    logic        eo;
    logic [7:0]  ec;
  } vec_t;
  vec_t tv[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input int n, output logic [15:0] s, output logic o, output logic [7:0] c);
    int unsigned t;
    s = 0; o = 0; c = 0;
    for (int i = 0; i < n; i++) begin
      t = 32'(s) + 32'(words_q[i]);
      if (t > 65535) begin
        o = 1'b1;
        if (c != 8'd255) c++;
      end
      s = t[15:0];
    end
  endfunction

  task automatic run_burst(input int n, input int gap, input bit poke, input int hold,
                           input logic [15:0] es, input logic eo, input logic [7:0] ec);
    int x0, r0, waited;
    x0 = xfers;
    r0 = ready_seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len = 8'(n);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.start = poke;
        bus.len = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      bus.in_data = words_q[i];
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data = 16'(32'($urandom));
    check("res_valid_latency", 32'(bus.res_valid), 32'd1);
    waited = 0;
    while (!bus.res_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("res_sum", 32'(bus.res_sum), 32'(es));
    check("res_ovf", 32'(bus.res_ovf), 32'(eo));
    check("res_ovf_cnt", 32'(bus.res_ovf_cnt), 32'(ec));
    check("transfers", 32'(xfers - x0), 32'(n));
    if (n == 0) check("zero_len_in_ready", 32'(ready_seen - r0), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.res_valid), 32'd1);
      check("hold_sum", 32'(bus.res_sum), 32'(es));
      check("hold_cnt", 32'(bus.res_ovf_cnt), 32'(ec));
    end
    bus.res_ready = 1'b1;
    bus.start = 1'b1;
    bus.len = 8'd2;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.start = 1'b0;
    check("res_valid_drop", 32'(bus.res_valid), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("res_sum_kept", 32'(bus.res_sum), 32'(es));
  endtask

  initial begin
    logic [15:0] s;
    logic o;
    logic [7:0] c;
    int n;
    tv[0] = '{3, '{16'h0001, 16'h0002, 16'h00C7}, 0, 16'h00CA, 1'b0, 8'd0};
    tv[1] = '{2, '{16'hFFFF, 16'h0001, 16'h0000}, 0, 16'h0000, 1'b1, 8'd1};
    tv[2] = '{3, '{16'hFFFF, 16'hFFFF, 16'hFFFF}, 4, 16'hFFFD, 1'b1, 8'd2};
    tv[3] = '{0, '{16'h0000, 16'h0000, 16'h0000}, 0, 16'h0000, 1'b0, 8'd0};
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_sum", 32'(bus.res_sum), 32'd0);
    check("rst_add_a", 32'(bus.add_a), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      words_q = {tv[i].w[0], tv[i].w[1], tv[i].w[2]};
      run_burst(tv[i].n, 0, 1'b0, tv[i].hold, tv[i].es, tv[i].eo, tv[i].ec);
      if (i == 0) begin
        @(negedge clk);
        bus.start = 1'b1;
        bus.len = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_data = 16'h0005;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid_add_a", 32'(bus.add_a), 32'h5);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_res_sum", 32'(bus.res_sum), 32'd0);
        check("mrst_add_a", 32'(bus.add_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_data = 16'h1234;
        bus.in_valid = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
          check("post_rst_busy", 32'(bus.busy), 32'd0);
        end
        check("idle_add_b", 32'(bus.add_b), 32'd0);
        check("idle_add_a", 32'(bus.add_a), 32'd0);
        bus.in_valid = 1'b0;
      end
    end
    words_q = {16'h0081, 16'h0000};
    run_burst(2, 3, 1'b1, 0, 16'h0081, 1'b0, 8'd0);
    for (int k = 0; k < 25; k++) begin
      n = int'($urandom_range(0, 6));
      words_q = {};
      for (int i = 0; i < n; i++)
        words_q.push_back($urandom_range(0, 1) != 0 ? 16'hFFFF - 16'($urandom_range(0, 255)) : 16'(32'($urandom)));
      model(n, s, o, c);
      run_burst(n, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), s, o, c);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
